// File: rtl/eeprom_pkg.sv
// rtl/eeprom_pkg.sv - shared states, timeout defaults and flag constants for the EEPROM arbiter
package eeprom_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } arb_state_t;

   localparam int TO_W_DEF   = 12;
   localparam int TO_MAX_DEF = 4095;

   localparam logic YES = 1'b1;
   localparam logic NO  = 1'b0;

   localparam int ADDR_W = 11;
   localparam int DATA_W = 8;

   function automatic logic [1:0] idx_to_onehot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin picker; on a tie the requester not served last wins
module rr_arb2
   import eeprom_pkg::*;
(
   input  logic [1:0] req_i,
   input  logic       last_i,
   output logic [1:0] gnt_o
);

   always_comb begin
      gnt_o = 2'b00;
      case (req_i)
         2'b01:   gnt_o = 2'b01;
         2'b10:   gnt_o = 2'b10;
         2'b11:   gnt_o = idx_to_onehot(~last_i);
         default: gnt_o = 2'b00;
      endcase
   end

endmodule

// File: rtl/eeprom_arbiter.sv
// rtl/eeprom_arbiter.sv - shares one EEPROM serial engine between two requesters with an ack timeout
module eeprom_arbiter
   import eeprom_pkg::*;
#(
   parameter int TO_W   = TO_W_DEF,
   parameter int TO_MAX = TO_MAX_DEF
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              req0_i,
   input  logic              req1_i,
   input  logic              we0_i,
   input  logic              we1_i,
   input  logic [ADDR_W-1:0] addr0_i,
   input  logic [ADDR_W-1:0] addr1_i,
   input  logic [DATA_W-1:0] wdata0_i,
   input  logic [DATA_W-1:0] wdata1_i,
   output logic              done0_o,
   output logic              done1_o,
   output logic              err_o,
   output logic [DATA_W-1:0] rdata_o,
   output logic              eng_wr_o,
   output logic              eng_rd_o,
   output logic [ADDR_W-1:0] eng_addr_o,
   output logic [DATA_W-1:0] eng_dout_o,
   output logic              eng_doe_o,
   input  logic [DATA_W-1:0] eng_din_i,
   input  logic              eng_ack_i
);

   arb_state_t        state_q;
   logic              win_q;
   logic              last_q;
   logic              we_q;
   logic [TO_W-1:0]   cnt_q;
   logic              done0_q;
   logic              done1_q;
   logic              err_q;
   logic [DATA_W-1:0] rdata_q;
   logic              eng_wr_q;
   logic              eng_rd_q;
   logic [ADDR_W-1:0] eng_addr_q;
   logic [DATA_W-1:0] eng_dout_q;
   logic              eng_doe_q;

   logic [1:0]        gnt;
   logic              win_d;
   logic              we_d;
   logic [ADDR_W-1:0] addr_d;
   logic [DATA_W-1:0] wdata_d;
   logic              timeout;

   rr_arb2 u_rr_arb2 (
      .req_i  ({req1_i, req0_i}),
      .last_i (last_q),
      .gnt_o  (gnt)
   );

   always_comb begin
      win_d   = gnt[1];
      we_d    = gnt[1] ? we1_i    : we0_i;
      addr_d  = gnt[1] ? addr1_i  : addr0_i;
      wdata_d = gnt[1] ? wdata1_i : wdata0_i;
   end

   // cnt_q counts completed WAIT cycles, so this is the TO_MAX-th one
   assign timeout = (cnt_q == TO_W'(TO_MAX - 1));

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= ST_IDLE;
         win_q      <= NO;
         last_q     <= YES;
         we_q       <= NO;
         cnt_q      <= '0;
         done0_q    <= NO;
         done1_q    <= NO;
         err_q      <= NO;
         rdata_q    <= '0;
         eng_wr_q   <= NO;
         eng_rd_q   <= NO;
         eng_addr_q <= '0;
         eng_dout_q <= '0;
         eng_doe_q  <= NO;
      end else begin
         eng_wr_q <= NO;
         eng_rd_q <= NO;
         done0_q  <= NO;
         done1_q  <= NO;
         err_q    <= NO;
         case (state_q)
            ST_IDLE: begin
               if (|gnt) begin
                  win_q      <= win_d;
                  we_q       <= we_d;
                  eng_addr_q <= addr_d;
                  eng_dout_q <= wdata_d;
                  eng_doe_q  <= we_d;
                  eng_wr_q   <= we_d;
                  eng_rd_q   <= ~we_d;
                  cnt_q      <= '0;
                  state_q    <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               state_q <= ST_WAIT;
            end
            ST_WAIT: begin
               if (eng_ack_i) begin
                  if (!we_q) begin
                     rdata_q <= eng_din_i;
                  end
                  {done1_q, done0_q} <= idx_to_onehot(win_q);
                  state_q            <= ST_DONE;
               end else if (timeout) begin
                  {done1_q, done0_q} <= idx_to_onehot(win_q);
                  err_q              <= YES;
                  state_q            <= ST_DONE;
               end else begin
                  cnt_q <= cnt_q + TO_W'(1);
               end
            end
            ST_DONE: begin
               last_q    <= win_q;
               eng_doe_q <= NO;
               state_q   <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign done0_o    = done0_q;
   assign done1_o    = done1_q;
   assign err_o      = err_q;
   assign rdata_o    = rdata_q;
   assign eng_wr_o   = eng_wr_q;
   assign eng_rd_o   = eng_rd_q;
   assign eng_addr_o = eng_addr_q;
   assign eng_dout_o = eng_dout_q;
   assign eng_doe_o  = eng_doe_q;

endmodule

// File: tb/tb_eeprom_arbiter.sv
// tb/tb_eeprom_arbiter.sv - scoreboard bench for eeprom_arbiter
module tb_eeprom_arbiter;

   localparam int TO_W   = 6;
   localparam int TO_MAX = 20;

   logic        clk, rst;
   logic        req0, req1, we0, we1;
   logic [10:0] addr0, addr1;
   logic [7:0]  wdata0, wdata1;
   logic        done0, done1, err;
   logic [7:0]  rdata;
   logic        eng_wr, eng_rd, eng_doe;
   logic [10:0] eng_addr;
   logic [7:0]  eng_dout, eng_din;
   logic        eng_ack;

   int vectors = 0;
   int miscmp  = 0;

   typedef struct packed {
      logic       idx;
      logic       err;
      logic [7:0] rdata;
   } rsp_t;

   typedef struct packed {
      logic        wr;
      logic        rd;
      logic [10:0] addr;
      logic [7:0]  dout;
      logic        doe;
   } eng_t;

   rsp_t rsp_q[$];
   eng_t eng_q[$];
   logic [7:0] exp_rdata = 8'h00;

   eeprom_arbiter #(.TO_W(TO_W), .TO_MAX(TO_MAX)) dut (
      .clk_i      (clk),
      .reset_i    (rst),
      .req0_i     (req0),
      .req1_i     (req1),
      .we0_i      (we0),
      .we1_i      (we1),
      .addr0_i    (addr0),
      .addr1_i    (addr1),
      .wdata0_i   (wdata0),
      .wdata1_i   (wdata1),
      .done0_o    (done0),
      .done1_o    (done1),
      .err_o      (err),
      .rdata_o    (rdata),
      .eng_wr_o   (eng_wr),
      .eng_rd_o   (eng_rd),
      .eng_addr_o (eng_addr),
      .eng_dout_o (eng_dout),
      .eng_doe_o  (eng_doe),
      .eng_din_i  (eng_din),
      .eng_ack_i  (eng_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscmp++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_done"},  {30'd0, done1, done0}, 0);
      chk({tag, "_err"},   {31'd0, err}, 0);
      chk({tag, "_rdata"}, {24'd0, rdata}, 0);
      chk({tag, "_strb"},  {30'd0, eng_wr, eng_rd}, 0);
      chk({tag, "_addr"},  {21'd0, eng_addr}, 0);
      chk({tag, "_dout"},  {24'd0, eng_dout}, 0);
      chk({tag, "_doe"},   {31'd0, eng_doe}, 0);
   endtask

   // Runs one transaction from IDLE; ack_cyc = WAIT cycle carrying ACK, 0 = never
   task automatic txn(input logic idx, input logic we, input logic [10:0] a, input logic [7:0] wd,
                      input int ack_cyc, input logic [7:0] din, input logic hold);
      if (idx == 1'b0) begin
         req0 = 1'b1; we0 = we; addr0 = a; wdata0 = wd;
      end else begin
         req1 = 1'b1; we1 = we; addr1 = a; wdata1 = wd;
      end
      eng_q.push_back('{wr: we, rd: ~we, addr: a, dout: (we ? wd : 8'h00), doe: we});
      if (!we && ack_cyc != 0) exp_rdata = din;
      rsp_q.push_back('{idx: idx, err: (ack_cyc == 0), rdata: exp_rdata});
      step();
      chk("strobe_latency", {30'd0, eng_wr, eng_rd}, {30'd0, we, ~we});
      if (!hold) begin
         if (idx == 1'b0) req0 = 1'b0; else req1 = 1'b0;
      end
      step();
      chk("strobe_width", {30'd0, eng_wr, eng_rd}, 0);
      chk("doe_wait", {31'd0, eng_doe}, {31'd0, we});
      for (int c = 1; c <= TO_MAX; c++) begin
         if (c == ack_cyc) begin
            eng_ack = 1'b1;
            eng_din = din;
         end
         step();
         eng_ack = 1'b0;
         if (c == ack_cyc) break;
      end
      chk("done_timing", {31'd0, (idx ? done1 : done0)}, 1);
      chk("doe_done", {31'd0, eng_doe}, {31'd0, we});
      chk("addr_stable", {21'd0, eng_addr}, {21'd0, a});
      step();
      chk("doe_idle", {31'd0, eng_doe}, 0);
      chk("done_once", {30'd0, done1, done0}, 0);
   endtask

   always @(negedge clk) begin
      rsp_t r;
      eng_t e;
      if (!rst) begin
         if (done0 || done1) begin
            if (rsp_q.size() == 0) begin
               vectors++;
               miscmp++;
               $display("FAIL unexpected_done: got done=%b%b expected none", done1, done0);
            end else begin
               r = rsp_q.pop_front();
               chk("done_idx", {30'd0, done1, done0}, {30'd0, (r.idx ? 2'b10 : 2'b01)});
               chk("err", {31'd0, err}, {31'd0, r.err});
               chk("rdata", {24'd0, rdata}, {24'd0, r.rdata});
            end
         end else if (err) begin
            vectors++;
            miscmp++;
            $display("FAIL err_alone: got err=1 expected err only with done");
         end
         if (eng_wr || eng_rd) begin
            if (eng_q.size() == 0) begin
               vectors++;
               miscmp++;
               $display("FAIL unexpected_strobe: got wr=%b rd=%b expected none", eng_wr, eng_rd);
            end else begin
               e = eng_q.pop_front();
               chk("eng_strobe", {30'd0, eng_wr, eng_rd}, {30'd0, e.wr, e.rd});
               chk("eng_addr", {21'd0, eng_addr}, {21'd0, e.addr});
               if (e.wr) chk("eng_dout", {24'd0, eng_dout}, {24'd0, e.dout});
               chk("eng_doe", {31'd0, eng_doe}, {31'd0, e.doe});
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      req0 = 0; req1 = 0; we0 = 0; we1 = 0;
      addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
      eng_din = 0; eng_ack = 0;
      repeat (3) step();
      chk_all_zero("reset");
      rst = 1'b0;

      txn(1'b0, 1'b1, 11'h123, 8'hA5, 2, 8'h00, 1'b0);
      txn(1'b1, 1'b0, 11'h7FF, 8'h00, 3, 8'h3C, 1'b0);

      // both held: last served was 1, so grants run 0,1,0,1
      req0 = 1; we0 = 1; addr0 = 11'h010; wdata0 = 8'h11;
      req1 = 1; we1 = 0; addr1 = 11'h020; wdata1 = 8'h00;
      for (int i = 0; i < 4; i++) begin
         if (i % 2 == 0) txn(1'b0, 1'b1, 11'h010, 8'h11, 1, 8'h00, 1'b1);
         else            txn(1'b1, 1'b0, 11'h020, 8'h00, 1, 8'h40 + 8'(i), 1'b1);
      end
      req0 = 0; req1 = 0;

      txn(1'b0, 1'b1, 11'h055, 8'h5A, 0, 8'h00, 1'b0);
      txn(1'b1, 1'b0, 11'h001, 8'h00, TO_MAX, 8'h99, 1'b0);
      txn(1'b1, 1'b0, 11'h002, 8'h00, 0, 8'h77, 1'b0);

      // reset while waiting for ACK
      req0 = 1; we0 = 1; addr0 = 11'h3AB; wdata0 = 8'hC3;
      eng_q.push_back('{wr: 1'b1, rd: 1'b0, addr: 11'h3AB, dout: 8'hC3, doe: 1'b1});
      step();
      req0 = 0;
      step();
      step();
      rst = 1'b1;
      step();
      chk_all_zero("mid_reset");
      rst = 1'b0;
      exp_rdata = 8'h00;
      repeat (3) begin
         step();
         chk("no_done_after_reset", {30'd0, done1, done0}, 0);
      end
      eng_ack = 1'b1;
      eng_din = 8'hEE;
      repeat (2) begin
         step();
         chk("stray_ack", {28'd0, done1, done0, eng_wr, eng_rd}, 0);
      end
      eng_ack = 1'b0;
      step();
      chk("stray_ack_rdata", {24'd0, rdata}, 0);

      // pointer after reset lets REQ0 win the first tie
      req0 = 1; we0 = 0; addr0 = 11'h100; wdata0 = 8'h00;
      req1 = 1; we1 = 1; addr1 = 11'h200; wdata1 = 8'h66;
      txn(1'b0, 1'b0, 11'h100, 8'h00, 2, 8'h5D, 1'b1);
      txn(1'b1, 1'b1, 11'h200, 8'h66, 2, 8'h00, 1'b1);
      req0 = 0; req1 = 0;

      repeat (3) step();
      chk("rsp_drain", rsp_q.size(), 0);
      chk("eng_drain", eng_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
      $finish;
   end

endmodule

// File: doc/eeprom_arbiter.md
EEPROM_ARBITER -- requirements
Module: eeprom_arbiter

Interface
REQ-001 SHALL have parameter TO_W, default 12, width of the acknowledge-timeout counter.
REQ-002 SHALL have parameter TO_MAX, default 4095, the number of WAIT cycles without ENG_ACK before the arbiter aborts.
REQ-003 SHALL use a single clock and a synchronous, active-high reset.
REQ-004 CLK  in  1  system clock; all state changes on posedge.
REQ-005 RESET  in  1  synchronous active-high reset.
REQ-006 REQ0, REQ1  in  1 each  requester n wants an EEPROM transaction.
REQ-007 WE0, WE1  in  1 each  1 = write, 0 = read.
REQ-008 ADDR0, ADDR1  in  11 each  EEPROM byte address.
REQ-009 WDATA0, WDATA1  in  8 each  write byte.
REQ-010 DONE0, DONE1  out  1 each  one-cycle completion pulse to requester n.
REQ-011 ERR  out  1  one-cycle pulse coincident with DONEn when the transaction timed out.
REQ-012 RDATA  out  8  read byte, valid while DONEn is high and held until the next read completes.
REQ-013 ENG_WR, ENG_RD  out  1 each  one-cycle start strobes to the EEPROM serial engine.
REQ-014 ENG_ADDR  out  11  address to engine.
REQ-015 ENG_DOUT  out  8  write byte to engine.
REQ-016 ENG_DOE  out  1  drive enable for the engine's bidirectional DATA bus.
REQ-017 ENG_DIN  in  8  read byte from engine.
REQ-018 ENG_ACK  in  1  engine end-of-cycle acknowledge.

Function
REQ-019 SHALL implement states IDLE, ISSUE, WAIT, DONE.
REQ-020 IDLE: if any REQn is sampled high, SHALL latch winner index, WEn, ADDRn, WDATAn, then go to ISSUE.
REQ-021 Arbitration SHALL be round-robin: a single request wins; with both high, the requester not served last wins.
REQ-022 ISSUE: SHALL assert ENG_WR (write) or ENG_RD (read) for exactly one cycle, then go to WAIT.
REQ-023 ENG_ADDR and ENG_DOUT SHALL be stable from ISSUE through DONE.
REQ-024 ENG_DOE SHALL be high from ISSUE through DONE for writes only.
REQ-025 The latency from REQ sampled high in IDLE to the start strobe SHALL be 1 cycle.
REQ-026 WAIT: on ENG_ACK high, SHALL capture ENG_DIN into RDATA (reads only) and go to DONE.
REQ-027 WAIT: the counter SHALL increment each cycle; on reaching TO_MAX without ACK, the arbiter SHALL go to DONE with ERR flagged.
REQ-028 If ACK and the timeout occur in the same cycle, ACK SHALL win and ERR SHALL stay 0.
REQ-029 DONE: SHALL pulse DONEn of the winner (plus ERR if flagged), update the round-robin pointer, and return to IDLE.
REQ-030 ENG_ACK outside WAIT SHALL be ignored.
REQ-031 REQn dropped mid-transaction SHALL NOT abort the transaction; DONEn still pulses.
REQ-032 A request held high through DONE SHALL be treated as a new request in the following IDLE.

Reset
REQ-033 RESET SHALL force the state to IDLE, all outputs to 0, the counter to 0, and the pointer so that REQ0 wins the first tie.
REQ-034 Reset asserted mid-transaction SHALL abandon it without a DONE pulse.

Structure
REQ-035 State encoding, TO_W/TO_MAX defaults and the YES/NO constants SHALL live in shared package eeprom_pkg.
REQ-036 The round-robin picker SHALL be sub-module rr_arb2 (two requests plus last-grant in, one-hot grant out).

Verification
REQ-037 REQ0 write, ADDR0=11'h123, WDATA0=8'hA5 -> ENG_WR pulse 1 cycle later, ENG_ADDR=123, ENG_DOUT=A5, DOE=1; ACK -> DONE0 next cycle, ERR=0.
REQ-038 REQ1 read, ADDR1=11'h7FF; ACK with ENG_DIN=8'h3C -> DONE1 with RDATA=3C, ENG_DOE=0 throughout.
REQ-039 REQ0 and REQ1 held continuously -> grants alternate 0,1,0,1.
REQ-040 No ACK -> DONEn plus ERR after TO_MAX WAIT cycles; ACK in the timeout cycle -> ERR=0.
REQ-041 RESET in WAIT -> IDLE next cycle, no DONE, all outputs 0; a stray ACK in IDLE produces no DONE.
